// File: rtl/phase_adjust_multi_pkg.sv
// Shared defaults for the multi-channel phase adjuster and its per-channel slice.
package phase_adjust_multi_pkg;

  localparam int DEF_NCH      = 2;
  localparam int DEF_PERIOD_W = 11;
  localparam int DEF_PHASE_W  = 7;

  // One extra bit so a channel held high for a whole period reads 2^PERIOD_W.
  function automatic int meas_w(input int period_w);
    return period_w + 1;
  endfunction

  localparam int DEF_MEAS_W = meas_w(DEF_PERIOD_W);

endpackage

// File: rtl/phase_adjust_multi_channel.sv
// One channel: shadow/active config, phase window compare, input synchroniser
// and high-cycle counter for the period measurement.
module phase_channel
  import phase_adjust_multi_pkg::*;
#(
  parameter  int PERIOD_W = DEF_PERIOD_W,
  parameter  int PHASE_W  = DEF_PHASE_W,
  localparam int MEAS_W   = meas_w(PERIOD_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] p,
  input  logic                wrap,
  input  logic                wr_en,
  input  logic [PHASE_W-1:0]  cfg_phase,
  input  logic [PHASE_W-1:0]  cfg_width,
  input  logic                cfg_level,
  input  logic                sig,
  output logic                pending,
  output logic                oe,
  output logic                d_out,
  output logic [MEAS_W-1:0]   meas
);

  logic [PHASE_W-1:0]  shadow_phase_q, shadow_phase_d;
  logic [PHASE_W-1:0]  shadow_width_q, shadow_width_d;
  logic                shadow_level_q, shadow_level_d;
  logic [PHASE_W-1:0]  active_phase_q, active_phase_d;
  logic [PHASE_W-1:0]  active_width_q, active_width_d;
  logic                active_level_q, active_level_d;
  logic                pending_q, pending_d;
  logic                oe_q, oe_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [MEAS_W-1:0]   cnt_q, cnt_d;
  logic [MEAS_W-1:0]   meas_q, meas_d;
  logic [PERIOD_W-1:0] diff;

  always_comb begin
    shadow_phase_d = shadow_phase_q;
    shadow_width_d = shadow_width_q;
    shadow_level_d = shadow_level_q;
    active_phase_d = active_phase_q;
    active_width_d = active_width_q;
    active_level_d = active_level_q;
    pending_d      = pending_q;

    if (wrap && pending_q) begin
      active_phase_d = shadow_phase_q;
      active_width_d = shadow_width_q;
      active_level_d = shadow_level_q;
      pending_d      = 1'b0;
    end

    // A write landing on the wrap edge only arms pending; it commits next wrap.
    if (wr_en) begin
      shadow_phase_d = cfg_phase;
      shadow_width_d = cfg_width;
      shadow_level_d = cfg_level;
      pending_d      = 1'b1;
    end

    // Modular distance makes windows that straddle the wrap contiguous.
    diff = p - PERIOD_W'(active_phase_q);
    oe_d = (diff < PERIOD_W'(active_width_q));

    sync1_d = sig;
    sync2_d = sync1_q;

    cnt_d  = cnt_q + MEAS_W'(sync2_q);
    meas_d = meas_q;
    if (wrap) begin
      meas_d = cnt_d;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_phase_q <= '0;
      shadow_width_q <= '0;
      shadow_level_q <= 1'b0;
      active_phase_q <= '0;
      active_width_q <= '0;
      active_level_q <= 1'b0;
      pending_q      <= 1'b0;
      oe_q           <= 1'b0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      cnt_q          <= '0;
      meas_q         <= '0;
    end else begin
      shadow_phase_q <= shadow_phase_d;
      shadow_width_q <= shadow_width_d;
      shadow_level_q <= shadow_level_d;
      active_phase_q <= active_phase_d;
      active_width_q <= active_width_d;
      active_level_q <= active_level_d;
      pending_q      <= pending_d;
      oe_q           <= oe_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      cnt_q          <= cnt_d;
      meas_q         <= meas_d;
    end
  end

  assign pending = pending_q;
  assign oe      = oe_q;
  assign d_out   = active_level_q;
  assign meas    = meas_q;

endmodule

// File: rtl/phase_adjust_multi.sv
// Multi-channel phase adjuster: shared period counter and config handshake,
// with one phase_channel per output. Pads stay in the parent.
module phase_adjust_multi
  import phase_adjust_multi_pkg::*;
#(
  parameter  int NCH      = DEF_NCH,
  parameter  int PERIOD_W = DEF_PERIOD_W,
  parameter  int PHASE_W  = DEF_PHASE_W,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int MEAS_W   = meas_w(PERIOD_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        sig,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [PHASE_W-1:0]    cfg_phase,
  input  logic [PHASE_W-1:0]    cfg_width,
  input  logic                  cfg_level,
  output logic [NCH-1:0]        oe,
  output logic [NCH-1:0]        d_out,
  output logic [NCH*MEAS_W-1:0] meas,
  output logic                  meas_valid
);

  logic [PERIOD_W-1:0] p_q, p_d;
  logic                meas_valid_q, meas_valid_d;
  logic                wrap;
  logic [NCH-1:0]      pending;

  always_comb begin
    p_d          = p_q + 1'b1;
    wrap         = (p_q == '1);
    meas_valid_d = wrap;
    cfg_ready    = rst && !pending[cfg_ch];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      p_q          <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign meas_valid = meas_valid_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    phase_channel #(
      .PERIOD_W (PERIOD_W),
      .PHASE_W  (PHASE_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .p         (p_q),
      .wrap      (wrap),
      .wr_en     (cfg_valid && cfg_ready && (cfg_ch == CH_W'(c))),
      .cfg_phase (cfg_phase),
      .cfg_width (cfg_width),
      .cfg_level (cfg_level),
      .sig       (sig[c]),
      .pending   (pending[c]),
      .oe        (oe[c]),
      .d_out     (d_out[c]),
      .meas      (meas[c*MEAS_W +: MEAS_W])
    );
  end

endmodule

// File: tb/tb_phase_adjust_multi.sv
// Directed bench for phase_adjust_multi at PERIOD_W=4, PHASE_W=4, NCH=2.
module tb_phase_adjust_multi;

  localparam int NCH      = 2;
  localparam int PERIOD_W = 4;
  localparam int PHASE_W  = 4;
  localparam int MEAS_W   = PERIOD_W + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NCH-1:0]        sig = '0;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [0:0]            cfg_ch = '0;
  logic [PHASE_W-1:0]    cfg_phase = '0;
  logic [PHASE_W-1:0]    cfg_width = '0;
  logic                  cfg_level = 1'b0;
  logic [NCH-1:0]        oe;
  logic [NCH-1:0]        d_out;
  logic [NCH*MEAS_W-1:0] meas;
  logic                  meas_valid;

  int   checks = 0;
  int   errors = 0;
  bit   toggle_en = 1'b0;
  logic [PERIOD_W-1:0] tb_p = '0;

  phase_adjust_multi #(
    .NCH      (NCH),
    .PERIOD_W (PERIOD_W),
    .PHASE_W  (PHASE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig        (sig),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_phase  (cfg_phase),
    .cfg_width  (cfg_width),
    .cfg_level  (cfg_level),
    .oe         (oe),
    .d_out      (d_out),
    .meas       (meas),
    .meas_valid (meas_valid)
  );

  always #5 clk = ~clk;

  // Reference period counter used to place stimulus at known phases.
  always @(posedge clk) tb_p <= rst ? tb_p + 4'd1 : 4'd0;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) sig[0] = ~sig[0];
  endtask

  task automatic wait_p(input logic [PERIOD_W-1:0] v);
    for (int i = 0; i < 40 && tb_p != v; i++) tick();
  endtask

  task automatic applyStimulus(input logic ch, input logic [3:0] ph,
                               input logic [3:0] w, input logic lvl);
    cfg_ch    = ch;
    cfg_phase = ph;
    cfg_width = w;
    cfg_level = lvl;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    #1;
  endtask

  task automatic wait_mv(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (meas_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  // Sample one full period of oe, indexed by the period counter value.
  task automatic capture_oe(output logic [15:0] m0, output logic [15:0] m1);
    m0 = '0;
    m1 = '0;
    for (int i = 0; i < 16; i++) begin
      m0[tb_p] = oe[0];
      m1[tb_p] = oe[1];
      tick();
    end
  endtask

  initial begin
    logic [15:0] m0, m1;
    int n;

    repeat (3) tick();
    checkOutput("rst_oe", 32'(oe), 32'd0);
    checkOutput("rst_dout", 32'(d_out), 32'd0);
    checkOutput("rst_meas", 32'(meas), 32'd0);
    checkOutput("rst_mv", 32'(meas_valid), 32'd0);
    checkOutput("rst_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("ready_after_rst", 32'(cfg_ready), 32'd1);

    // Basic config of both channels, committed at the first wrap.
    applyStimulus(1'b0, 4'd3, 4'd4, 1'b1);
    applyStimulus(1'b1, 4'd14, 4'd4, 1'b0);
    wait_p(4'd15);
    checkOutput("dout_before_commit", 32'(d_out), 32'd0);
    tick();
    checkOutput("dout_commit", 32'(d_out), 32'b01);
    checkOutput("mv_first_wrap", 32'(meas_valid), 32'd1);
    checkOutput("meas_sig_low", 32'(meas), 32'd0);
    cfg_ch = 1'b0;
    #1;
    checkOutput("ready_after_commit", 32'(cfg_ready), 32'd1);
    tick();
    checkOutput("mv_one_cycle", 32'(meas_valid), 32'd0);
    wait_p(4'd4);
    capture_oe(m0, m1);
    checkOutput("oe0_window", 32'(m0), 32'h00F0);
    checkOutput("oe1_wrap_window", 32'(m1), 32'h8007);

    // Pending ch0 stalls a second ch0 write but not a ch1 write.
    wait_p(4'd5);
    cfg_ch = 1'b0; cfg_phase = 4'd3; cfg_width = 4'd4; cfg_level = 1'b0;
    cfg_valid = 1'b1;
    #1;
    checkOutput("ready_ch0_free", 32'(cfg_ready), 32'd1);
    tick();
    cfg_width = 4'd0; cfg_level = 1'b1;
    #1;
    checkOutput("ready_ch0_pending", 32'(cfg_ready), 32'd0);
    tick();
    tick();
    checkOutput("ready_ch0_stall", 32'(cfg_ready), 32'd0);
    cfg_ch = 1'b1; cfg_phase = 4'd14; cfg_width = 4'd0; cfg_level = 1'b1;
    #1;
    checkOutput("ready_ch1_free", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    wait_p(4'd15);
    checkOutput("dout_hold_pending", 32'(d_out), 32'b01);
    tick();
    checkOutput("dout_both_commit", 32'(d_out), 32'b10);
    cfg_ch = 1'b0;
    #1;
    checkOutput("ready_ch0_cleared", 32'(cfg_ready), 32'd1);
    wait_p(4'd4);
    capture_oe(m0, m1);
    checkOutput("oe0_unchanged", 32'(m0), 32'h00F0);
    checkOutput("oe1_width0", 32'(m1), 32'h0000);

    // Write landing on the wrap edge waits a whole extra period.
    wait_p(4'd15);
    cfg_ch = 1'b0; cfg_phase = 4'd0; cfg_width = 4'd2; cfg_level = 1'b1;
    cfg_valid = 1'b1;
    #1;
    checkOutput("ready_at_max", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    #1;
    checkOutput("dout_no_commit_at_wrap", 32'(d_out), 32'b10);
    n = 0;
    for (int i = 0; i < 40 && !cfg_ready; i++) begin
      n++;
      tick();
    end
    checkOutput("ready_low_cycles", 32'(n), 32'd16);
    checkOutput("dout_late_commit", 32'(d_out), 32'b11);
    wait_p(4'd4);
    capture_oe(m0, m1);
    checkOutput("oe0_phase0", 32'(m0), 32'h0006);

    // Measurement: constant levels, then a toggling input.
    wait_p(4'd2);
    sig = 2'b01;
    wait_mv("mv_seen_a");
    wait_mv("mv_seen_b");
    checkOutput("meas0_full", 32'(meas[MEAS_W-1:0]), 32'd16);
    checkOutput("meas1_zero", 32'(meas[2*MEAS_W-1:MEAS_W]), 32'd0);
    tick();
    checkOutput("mv_pulse_end", 32'(meas_valid), 32'd0);
    checkOutput("meas0_held", 32'(meas[MEAS_W-1:0]), 32'd16);
    toggle_en = 1'b1;
    wait_mv("mv_seen_c");
    wait_mv("mv_seen_d");
    checkOutput("meas0_toggle", 32'(meas[MEAS_W-1:0]), 32'd8);
    toggle_en = 1'b0;
    sig = 2'b01;

    // Reset mid-period with a write pending on ch1.
    wait_p(4'd7);
    applyStimulus(1'b1, 4'd1, 4'd3, 1'b0);
    checkOutput("ready_ch1_pending", 32'(cfg_ready), 32'd0);
    wait_p(4'd9);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_oe", 32'(oe), 32'd0);
    checkOutput("mid_rst_dout", 32'(d_out), 32'd0);
    checkOutput("mid_rst_meas", 32'(meas), 32'd0);
    checkOutput("mid_rst_mv", 32'(meas_valid), 32'd0);
    checkOutput("mid_rst_pending", 32'(cfg_ready), 32'd1);
    n = 1;
    for (int i = 0; i < 40 && !meas_valid; i++) begin
      tick();
      n++;
    end
    checkOutput("mv_after_release", 32'(n), 32'd17);
    checkOutput("meas0_after_rst", 32'(meas[MEAS_W-1:0]), 32'd14);
    checkOutput("meas1_after_rst", 32'(meas[2*MEAS_W-1:MEAS_W]), 32'd0);
    checkOutput("dout_discarded", 32'(d_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
